// File: rtl/regfile_pkg.sv
// Shared constants and port-slice helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int ZERO_REG     = 0;

    // LSB of port i within a packed bus of w-bit slices
    function automatic int slice_lo(input int port, input int w);
        return port * w;
    endfunction

    function automatic int slice_hi(input int port, input int w);
        return port * w + w - 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: r0/out-of-range zeroing and pending lookup.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] pend_vec,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              pending
);

    logic in_range;

    always_comb begin
        data     = '0;
        pending  = 1'b0;
        in_range = (int'(idx) != ZERO_REG) && (int'(idx) < NUM_REGS);
        if (in_range) begin
            data    = regs[idx];
            pending = pend_vec[idx];
        end
`ifdef REGFILE_BYPASS_EN
        if (in_range && rst_n && wr_en && (wr_idx == idx)) begin
            data    = wr_data;
            pending = 1'b0;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{rst_n, wr_en, wr_idx, wr_data};
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending-write scoreboard for long-latency ops.
// REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_setReg,
    output logic [NUM_RD-1:0]        rd_pending,
    output logic [NUM_REGS-1:0]      pend_vec,
    output logic                     dbl_issue_err
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                err_q, err_d;
    logic                wr_ok, set_ok;

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        err_d  = err_q;
        wr_ok  = ctrl_writeEnable
              && (int'(ctrl_writeReg) != ZERO_REG)
              && (int'(ctrl_writeReg) < NUM_REGS);
        set_ok = pend_set
              && (int'(pend_setReg) != ZERO_REG)
              && (int'(pend_setReg) < NUM_REGS);
        if (wr_ok) begin
            mem_d[ctrl_writeReg]  = data_writeReg;
            pend_d[ctrl_writeReg] = 1'b0;
        end
        // clear applied first, so a re-issue racing its own writeback is legal
        if (set_ok) begin
            if (pend_d[pend_setReg]) err_d = 1'b1;
            pend_d[pend_setReg] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pend_vec      = pend_q;
    assign dbl_issue_err = err_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W)
        ) u_port (
            .rst_n   (reset),
            .idx     (ctrl_readReg[slice_hi(i, ADDR_W):slice_lo(i, ADDR_W)]),
            .regs    (mem_q),
            .pend_vec(pend_q),
            .wr_en   (ctrl_writeEnable),
            .wr_idx  (ctrl_writeReg),
            .wr_data (data_writeReg),
            .data    (data_readReg[slice_hi(i, DATA_W):slice_lo(i, DATA_W)]),
            .pending (rd_pending[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 2-port build plus a 4-port/16-reg build.
module tb_regfile_scoreboard;

    logic         clock;
    logic         reset;

    logic         we;
    logic [4:0]   wreg;
    logic [31:0]  wdata;
    logic [9:0]   rreg;
    logic [63:0]  rdata;
    logic         pset;
    logic [4:0]   preg;
    logic [1:0]   rpend;
    logic [31:0]  pvec;
    logic         err;

    logic         w_we;
    logic [3:0]   w_wreg;
    logic [31:0]  w_wdata;
    logic [15:0]  w_rreg;
    logic [127:0] w_rdata;
    logic         w_pset;
    logic [3:0]   w_preg;
    logic [3:0]   w_rpend;
    logic [15:0]  w_pvec;
    logic         w_err;

    int n_checks;
    int n_fail;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_scoreboard dut (
        .clock           (clock),
        .reset           (reset),
        .ctrl_writeEnable(we),
        .ctrl_writeReg   (wreg),
        .data_writeReg   (wdata),
        .ctrl_readReg    (rreg),
        .data_readReg    (rdata),
        .pend_set        (pset),
        .pend_setReg     (preg),
        .rd_pending      (rpend),
        .pend_vec        (pvec),
        .dbl_issue_err   (err)
    );

    regfile_scoreboard #(
        .DATA_W  (32),
        .NUM_REGS(16),
        .ADDR_W  (4),
        .NUM_RD  (4)
    ) dut4 (
        .clock           (clock),
        .reset           (reset),
        .ctrl_writeEnable(w_we),
        .ctrl_writeReg   (w_wreg),
        .data_writeReg   (w_wdata),
        .ctrl_readReg    (w_rreg),
        .data_readReg    (w_rdata),
        .pend_set        (w_pset),
        .pend_setReg     (w_preg),
        .rd_pending      (w_rpend),
        .pend_vec        (w_pvec),
        .dbl_issue_err   (w_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        @(negedge clock);
        rreg = {5'd5, 5'd1};
        #1;
        n_checks++;
        if (rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 64'h0);
        end
        n_checks++;
        if (pvec !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pvec: got %h expected %h", pvec, 32'h0);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF;
        rreg = {5'd5, 5'd5};
        @(posedge clock); #1;
        n_checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_port0: got %h expected %h", rdata[31:0], 32'hDEADBEEF);
        end
        n_checks++;
        if (rdata[63:32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_port1: got %h expected %h", rdata[63:32], 32'hDEADBEEF);
        end
        @(negedge clock);
        wreg = 5'd0; wdata = 32'h1234;
        rreg = {5'd5, 5'd0};
        @(posedge clock); #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_zero: got %h expected %h", rdata[31:0], 32'h0);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
        @(negedge clock);
        we = 1'b1; wreg = 5'd9; wdata = 32'h11111111;
        @(negedge clock);
        wdata = 32'hA5A5A5A5;
        rreg = {5'd5, 5'd9};
        #1;
        exp_now = BYP ? 32'hA5A5A5A5 : 32'h11111111;
        n_checks++;
        if (rdata[31:0] !== exp_now) begin
            n_fail++;
            $display("FAIL same_cycle_rd: got %h expected %h", rdata[31:0], exp_now);
        end
        @(posedge clock); #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL next_cycle_rd: got %h expected %h", rdata[31:0], 32'hA5A5A5A5);
        end
    endtask

    task automatic test_pending();
        logic exp_p;
        @(negedge clock);
        pset = 1'b1; preg = 5'd7;
        rreg = {5'd7, 5'd5};
        #1;
        n_checks++;
        if (rpend[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_before_edge: got %b expected 0", rpend[1]);
        end
        @(posedge clock); #1;
        pset = 1'b0;
        #1;
        n_checks++;
        if (rpend[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_after_set: got %b expected 1", rpend[1]);
        end
        @(negedge clock);
        we = 1'b1; wreg = 5'd7; wdata = 32'h42;
        #1;
        exp_p = BYP ? 1'b0 : 1'b1;
        n_checks++;
        if (rpend[1] !== exp_p) begin
            n_fail++;
            $display("FAIL pend_wr_cycle: got %b expected %b", rpend[1], exp_p);
        end
        @(posedge clock); #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rpend[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_cleared: got %b expected 0", rpend[1]);
        end
        n_checks++;
        if (rdata[63:32] !== 32'h42) begin
            n_fail++;
            $display("FAIL pend_data: got %h expected %h", rdata[63:32], 32'h42);
        end
    endtask

    task automatic test_set_clear();
        @(negedge clock);
        pset = 1'b1; preg = 5'd3;
        @(posedge clock); #1;
        pset = 1'b0;
        @(negedge clock);
        pset = 1'b1; preg = 5'd3;
        we = 1'b1; wreg = 5'd3; wdata = 32'h33;
        @(posedge clock); #1;
        pset = 1'b0; we = 1'b0;
        #1;
        n_checks++;
        if (pvec[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got %b expected 1", pvec[3]);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_dbl_err: got %b expected 0", err);
        end
        @(negedge clock);
        pset = 1'b1; preg = 5'd3;
        @(posedge clock); #1;
        pset = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dbl_err_set: got %b expected 1", err);
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dbl_err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clock);
        rreg = {5'd9, 5'd5};
        #1;
        n_checks++;
        if (rdata !== {32'hA5A5A5A5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pre_reset_rd: got %h expected %h",
                     rdata, {32'hA5A5A5A5, 32'hDEADBEEF});
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reset_rd: got %h expected %h", rdata, 64'h0);
        end
        n_checks++;
        if (pvec !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_pvec: got %h expected %h", pvec, 32'h0);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_err: got %b expected 0", err);
        end
        @(negedge clock);
        reset = 1'b1;
        we = 1'b1; wreg = 5'd2; wdata = 32'h7;
        rreg = {5'd9, 5'd2};
        @(posedge clock); #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata !== {32'h0, 32'h7}) begin
            n_fail++;
            $display("FAIL post_reset_wr: got %h expected %h", rdata, {32'h0, 32'h7});
        end
    endtask

    task automatic test_wide();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            w_we = 1'b1; w_wreg = 4'(k); w_wdata = 32'(k);
        end
        @(negedge clock);
        w_we = 1'b0;
        w_rreg = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (w_rdata[p*32 +: 32] !== 32'(p + 1)) begin
                n_fail++;
                $display("FAIL wide_port%0d: got %h expected %h",
                         p, w_rdata[p*32 +: 32], 32'(p + 1));
            end
        end
        @(negedge clock);
        w_pset = 1'b1; w_preg = 4'd2;
        @(negedge clock);
        w_preg = 4'd0;
        @(negedge clock);
        w_pset = 1'b0;
        n_checks++;
        if (w_pvec !== 16'h0004) begin
            n_fail++;
            $display("FAIL wide_r0_set: got %h expected %h", w_pvec, 16'h0004);
        end
        n_checks++;
        if (w_rpend !== 4'b0010) begin
            n_fail++;
            $display("FAIL wide_rpend: got %b expected %b", w_rpend, 4'b0010);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        we = 1'b0; wreg = '0; wdata = '0; rreg = '0;
        pset = 1'b0; preg = '0;
        w_we = 1'b0; w_wreg = '0; w_wdata = '0; w_rreg = '0;
        w_pset = 1'b0; w_preg = '0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_pending();
        test_set_clear();
        test_mid_reset();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
